layer_seq: RTL and testbench
============================

Name: layer_seq

Overview:
- Time-multiplexed sequencer for one LogicNets layer.
- Instead of NEURONS parallel neuron LUT instances, one shared neuron LUT is evaluated once per neuron, in turn.
- Captures the layer input vector M0, gathers each neuron's fan-in bits from a connectivity table, and drives the shared LUT's select and address.
- Assembles the per-neuron outputs into M1 and presents the result with a valid/ready handshake to the next layer.

Parameters:
- IN_WIDTH, 8, width of layer input vector M0.
- NEURONS, 3, neurons in the layer; evaluated in index order 0..NEURONS-1.
- FANIN_BITS, 4, bits per neuron LUT address (fan-in × input bitwidth).
- OUT_BITS, 2, bits produced per neuron.
- CONN, per-neuron {1,0,5,4}, packed table of NEURONS×FANIN_BITS indices, each $clog2(IN_WIDTH) bits.
  - Entry k of neuron n gives the M0 bit placed at lut_addr[FANIN_BITS-1-k].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  M0 valid.
- in_ready  out  1  sequencer can accept M0.
- M0  in  IN_WIDTH  layer input vector.
- lut_en  out  1  lut_sel/lut_addr carry a live request this cycle.
- lut_sel  out  $clog2(NEURONS)  neuron index presented to the shared LUT.
- lut_addr  out  FANIN_BITS  gathered fan-in bits for lut_sel.
- lut_data  in  OUT_BITS  shared LUT result.
- out_valid  out  1  M1 holds a complete layer result.
- out_ready  in  1  downstream accepts M1.
- M1  out  NEURONS×OUT_BITS  layer output; neuron n occupies M1[n*OUT_BITS +: OUT_BITS].

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, in_ready 1, out_valid 0, lut_en 0, lut_sel 0, lut_addr 0, M1 0, captured input 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register M0 into in_q, set idx=0, go to EVAL.
  - EVAL: lut_en=1, lut_sel=idx, lut_addr=gather(in_q, CONN[idx]), all registered off idx/in_q. lut_data is combinational in the same cycle and is written into slice idx of M1 at the clock edge. idx increments. After idx==NEURONS-1 is written, go to DONE.
  - DONE: out_valid=1; M1 is stable. On out_ready:
    - with in_valid: capture the new M0, go to EVAL (back-to-back).
    - without in_valid: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is the only combinational input-to-output path.
- Latency: M0 accepted at edge E gives out_valid high from edge E+NEURONS+1. Throughput is one layer per NEURONS+1 cycles.
- Slice handling:
  - M1 slices not yet rewritten keep their previous values during EVAL. Downstream must sample only when out_valid=1.
  - Only slices 0..NEURONS-1 are written; idx never wraps beyond NEURONS-1.
- out_ready low in DONE: hold indefinitely; M1, out_valid and in_ready are unchanged.
- lut_en=0 outside EVAL. lut_sel and lut_addr hold their last values then.
- in_valid outside IDLE/DONE is ignored (in_ready=0).
- rst mid-EVAL or mid-DONE aborts the evaluation. Next cycle all reset values apply and the partial result is discarded.
- NEURONS==1: EVAL lasts exactly one cycle.

Optional Feature:
- LAYER_SEQ_LUT_REG_EN.
- Defined: the shared LUT has a registered output, so lut_data corresponds to the request issued the previous cycle.
  - EVAL keeps issuing idx 0..NEURONS-1 back-to-back.
  - A one-cycle-delayed write pointer stores lut_data.
  - One extra drain cycle with lut_en=0 follows the last request.
  - Latency becomes NEURONS+2 edges.
- Undefined: combinational LUT timing as above; no delayed pointer logic is present.

Decomposition:
- Package layer_seq_pkg holds:
  - state enum {IDLE, EVAL, DONE};
  - helper functions for index widths ($clog2 of NEURONS and IN_WIDTH);
  - the default CONN constant.
- Sub-module layer_seq_gather (combinational): given in_q and a neuron index, returns lut_addr via the CONN bit-select. It is instanced once in layer_seq.

Test Plan (bench LUT model: lut_data = (lut_addr[1:0] + lut_sel) mod 4; default params):
- Reset then idle: rst high for 2 cycles. Expect in_ready=1, out_valid=0, M1=0, lut_en=0 for the cycles that follow.
- Single layer: M0=8'h36, in_valid for one cycle. Expect lut_addr=4'b1011 for 3 cycles with lut_sel 0,1,2; then out_valid at E+4 with M1=6'b010011.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Expect M1 stable at 6'h13, in_ready=0, lut_en=0 throughout; release and expect IDLE next cycle.
- Back-to-back: M0=8'h36 then 8'h00, with in_valid and out_ready held high. Expect second acceptance in the DONE cycle and second M1=6'b100100 four edges later, with no idle gap.
- Reset mid-EVAL: assert rst during lut_sel=1. Expect all outputs at reset values next cycle and no out_valid thereafter until a new M0 is accepted.
- With LAYER_SEQ_LUT_REG_EN and a registered bench LUT: single layer 8'h36. Expect M1=6'b010011 with out_valid at E+5.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types and defaults for the time-multiplexed LogicNets layer sequencer.
// Width helpers, the default connectivity row and the FSM state encoding live here.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a neuron index; never below one bit so NEURONS==1 still gets a port.
    function automatic int sel_width(input int neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

    // Width of one connectivity entry (an index into M0).
    function automatic int conn_idx_width(input int in_width);
        return (in_width > 1) ? $clog2(in_width) : 1;
    endfunction

    // One neuron's row: entries k=0..3 are M0 bits 1,0,5,4 (entry 0 in the low bits).
    localparam logic [11:0] CONN_NEURON_DEFAULT = {3'd4, 3'd5, 3'd0, 3'd1};

endpackage

// File: rtl/layer_seq_gather.sv
// Fan-in gather: picks the M0 bits listed in CONN for neuron sel and packs them
// MSB-first into the shared LUT address.
module layer_seq_gather
    import layer_seq_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int NEURONS    = 3,
    parameter int FANIN_BITS = 4,
    parameter logic [NEURONS*FANIN_BITS*conn_idx_width(IN_WIDTH)-1:0] CONN =
        {NEURONS{CONN_NEURON_DEFAULT}}
)(
    input  logic [IN_WIDTH-1:0]            in_vec,
    input  logic [sel_width(NEURONS)-1:0]  sel,
    output logic [FANIN_BITS-1:0]          addr
);

    localparam int SEL_W = sel_width(NEURONS);
    localparam int IDX_W = conn_idx_width(IN_WIDTH);

    always_comb begin
        addr = '0;
        for (int n = 0; n < NEURONS; n++) begin
            if (sel == SEL_W'(n)) begin
                for (int k = 0; k < FANIN_BITS; k++) begin
                    addr[FANIN_BITS-1-k] = in_vec[CONN[(n*FANIN_BITS+k)*IDX_W +: IDX_W]];
                end
            end
        end
    end

endmodule

// File: rtl/layer_seq.sv
// Sequencer that evaluates one shared neuron LUT per neuron in turn and assembles M1.
// Define LAYER_SEQ_LUT_REG_EN when the shared LUT has a registered output.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int NEURONS    = 3,
    parameter int FANIN_BITS = 4,
    parameter int OUT_BITS   = 2,
    parameter logic [NEURONS*FANIN_BITS*conn_idx_width(IN_WIDTH)-1:0] CONN =
        {NEURONS{CONN_NEURON_DEFAULT}}
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            M0,
    output logic                           lut_en,
    output logic [sel_width(NEURONS)-1:0]  lut_sel,
    output logic [FANIN_BITS-1:0]          lut_addr,
    input  logic [OUT_BITS-1:0]            lut_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NEURONS*OUT_BITS-1:0]    M1
);

    localparam int SEL_W = sel_width(NEURONS);
    localparam int M1_W  = NEURONS * OUT_BITS;

    state_e                 state_q, state_d;
    logic [IN_WIDTH-1:0]    in_q, in_d;
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic                   issue_q, issue_d;
    logic                   lut_en_q, lut_en_d;
    logic [SEL_W-1:0]       lut_sel_q, lut_sel_d;
    logic [FANIN_BITS-1:0]  lut_addr_q, lut_addr_d;
    logic [M1_W-1:0]        m1_q, m1_d;
    logic [FANIN_BITS-1:0]  gather_addr;
    logic                   wr_en;
    logic [SEL_W-1:0]       wr_sel;

    layer_seq_gather #(
        .IN_WIDTH   (IN_WIDTH),
        .NEURONS    (NEURONS),
        .FANIN_BITS (FANIN_BITS),
        .CONN       (CONN)
    ) u_gather (
        .in_vec (in_q),
        .sel    (idx_q),
        .addr   (gather_addr)
    );

`ifdef LAYER_SEQ_LUT_REG_EN
    // LUT result trails its request by one cycle, so the write pointer does too.
    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;

    assign wr_en_d  = lut_en_q;
    assign wr_sel_d = lut_sel_q;
    assign wr_en    = wr_en_q;
    assign wr_sel   = wr_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q  <= 1'b0;
            wr_sel_q <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            wr_sel_q <= wr_sel_d;
        end
    end
`else
    assign wr_en  = lut_en_q;
    assign wr_sel = lut_sel_q;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign lut_en    = lut_en_q;
    assign lut_sel   = lut_sel_q;
    assign lut_addr  = lut_addr_q;
    assign M1        = m1_q;

    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        idx_d      = idx_q;
        issue_d    = issue_q;
        lut_en_d   = 1'b0;
        lut_sel_d  = lut_sel_q;
        lut_addr_d = lut_addr_q;
        m1_d       = m1_q;

        case (state_q)
            IDLE: ;
            EVAL: begin
                if (issue_q) begin
                    lut_en_d   = 1'b1;
                    lut_sel_d  = idx_q;
                    lut_addr_d = gather_addr;
                    if (idx_q == SEL_W'(NEURONS - 1)) begin
                        issue_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (wr_en) begin
                    for (int n = 0; n < NEURONS; n++) begin
                        if (wr_sel == SEL_W'(n)) begin
                            m1_d[n*OUT_BITS +: OUT_BITS] = lut_data;
                        end
                    end
                    if (wr_sel == SEL_W'(NEURONS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance from IDLE or straight out of DONE (back-to-back layers).
        if (in_valid && in_ready) begin
            in_d    = M0;
            idx_d   = '0;
            issue_d = 1'b1;
            state_d = EVAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_q       <= '0;
            idx_q      <= '0;
            issue_q    <= 1'b0;
            lut_en_q   <= 1'b0;
            lut_sel_q  <= '0;
            lut_addr_q <= '0;
            m1_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            idx_q      <= idx_d;
            issue_q    <= issue_d;
            lut_en_q   <= lut_en_d;
            lut_sel_q  <= lut_sel_d;
            lut_addr_q <= lut_addr_d;
            m1_q       <= m1_d;
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq with a shared LUT model lut_data = (lut_addr[1:0] + lut_sel) mod 4.
// Define LAYER_SEQ_LUT_REG_EN to exercise the registered-LUT variant.
module tb_layer_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] M0;
    logic       lut_en;
    logic [1:0] lut_sel;
    logic [3:0] lut_addr;
    logic [1:0] lut_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] M1;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef LAYER_SEQ_LUT_REG_EN
    localparam int LAT = 5;
    logic [1:0] lut_q = 2'd0;
    always @(posedge clk) lut_q <= 2'(lut_addr[1:0] + lut_sel);
    assign lut_data = lut_q;
`else
    localparam int LAT = 4;
    assign lut_data = 2'(lut_addr[1:0] + lut_sel);
`endif

    always #5 clk = ~clk;

    layer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M0        (M0),
        .lut_en    (lut_en),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .M1        (M1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and park on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after the acceptance edge; counts edges until out_valid and checks requests.
    task automatic run_layer(input string tag, input logic [3:0] exp_addr, input logic [5:0] exp_m1);
        int lat  = 0;
        int nreq = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
            if (lut_en) begin
                chk({tag, "_sel"}, 32'(lut_sel), 32'(nreq));
                chk({tag, "_addr"}, 32'(lut_addr), 32'(exp_addr));
                nreq++;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_nreq"}, 32'(nreq), 32'd3);
        chk({tag, "_m1"}, 32'(M1), 32'(exp_m1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        M0        = 8'h00;

        // Reset then idle
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_lut_en", 32'(lut_en), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_m1", 32'(M1), 32'd0);
            chk("idle_lut_en", 32'(lut_en), 32'd0);
        end

        // Single layer, then backpressure
        M0        = 8'h36;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("single_first_lut_en", 32'(lut_en), 32'd0);
        run_layer("single", 4'b1011, 6'b010011);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_m1", 32'(M1), 32'h13);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_lut_en", 32'(lut_en), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back layers
        out_ready = 1'b1;
        M0        = 8'h36;
        in_valid  = 1'b1;
        step();
        M0 = 8'h00;
        chk("b2b_eval_in_ready", 32'(in_ready), 32'd0);
        run_layer("b2b_first", 4'b1011, 6'b010011);
        chk("b2b_done_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_no_gap_out_valid", 32'(out_valid), 32'd0);
        chk("b2b_no_gap_in_ready", 32'(in_ready), 32'd0);
        run_layer("b2b_second", 4'b0000, 6'b100100);
        step();
        chk("b2b_idle_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of evaluation
        M0       = 8'h36;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !(lut_en && lut_sel == 2'd1); i++) begin
            step();
        end
        chk("mid_rst_reached_sel1", 32'(lut_en && lut_sel == 2'd1), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lut_en", 32'(lut_en), 32'd0);
        chk("mid_rst_lut_sel", 32'(lut_sel), 32'd0);
        chk("mid_rst_lut_addr", 32'(lut_addr), 32'd0);
        chk("mid_rst_m1", 32'(M1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        end
        M0       = 8'h00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_layer("post_rst", 4'b0000, 6'b100100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
